// File: rtl/k2red_unscale.sv
// Strips the k^2 factor left by K2-RED: R = X * 2^(2m) mod q, using 2m modular doublings.
// Uses valid/ready on both sides and processes one operand at a time.
module k2red_unscale #(
  parameter int W  = 32,
  parameter int MW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  X,
  input  logic [W-1:0]  Q,
  input  logic [MW-1:0] m,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  R,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, nxt;
  logic [W-1:0]  qr, acc, pre, step;
  logic [MW:0]   cnt;
  logic [W:0]    dbl, diff;

  // Doubling needs one extra bit so q close to 2^W cannot overflow the compare.
  always_comb begin
    pre  = (X >= Q) ? X - Q : X;
    dbl  = {acc, 1'b0};
    diff = dbl - {1'b0, qr};
    step = (dbl >= {1'b0, qr}) ? diff[W-1:0] : dbl[W-1:0];
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid)    nxt = RUN;
      RUN:     if (cnt == '0)   nxt = DONE;
      DONE:    if (out_ready)   nxt = IDLE;
      default:                  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      qr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      R         <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (in_valid) begin
          qr  <= Q;
          cnt <= {m, 1'b0};
          acc <= pre;
        end
        RUN: if (cnt != '0) begin
          acc <= step;
          cnt <= cnt - (MW+1)'(1);
        end else begin
          R         <= acc;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN) || (state == DONE);

endmodule
